sample_capture: RTL

//  Write side of the scope sample buffer: captures a triggered window of ADC samples

---
 rtl/sample_capture.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sample_capture.sv
// Triggered capture of ADC samples into a circular RAM that freezes once the window is full.
// Build option: define AUTO_TRIG_EN to force a trigger after AUTO_TMO valid samples in WAIT_TRIG.
module sample_capture #(
  parameter int DEPTH_W  = 6,
  parameter int SAMPLE_W = 6,
  parameter int PRETRIG  = 16,
  parameter int AUTO_TMO = 4095
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                arm,
  input  logic [DEPTH_W-1:0]  rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                ready,
  output logic                busy,
  // FSM state for checkers: 0 IDLE, 1 PRE, 2 WAIT_TRIG, 3 POST, 4 DONE
  output logic [2:0]          dbg_state
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam int CNT_W = DEPTH_W + 1;
  localparam logic [CNT_W-1:0]   PRE_LAST  = CNT_W'(PRETRIG - 1);
  localparam logic [CNT_W-1:0]   POST_LAST = CNT_W'(DEPTH - PRETRIG - 1);
  localparam logic [DEPTH_W-1:0] PRE_OFS   = DEPTH_W'(PRETRIG);

  if (PRETRIG < 1 || PRETRIG >= DEPTH || AUTO_TMO < 1) begin : g_bad_cfg
    $error("sample_capture: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              state;
  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [DEPTH_W-1:0]  wr_ptr;
  logic [DEPTH_W-1:0]  trig_ptr;
  logic [DEPTH_W-1:0]  rd_idx;
  logic [CNT_W-1:0]    cnt;
  logic [SAMPLE_W-1:0] prev_sample;
  logic                prev_ok;
  logic                capturing;
  logic                wr_en;
  logic                crossing;
  logic                fire;

  assign capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
  // arm wins over a coincident sample: it is neither stored nor remembered
  assign wr_en     = capturing && sample_valid && !arm;
  assign crossing  = prev_ok && (prev_sample < trig_level) && (sample >= trig_level);
  assign busy      = capturing;
  assign dbg_state = state;
  assign rd_idx    = (trig_ptr - PRE_OFS) + rd_addr;

`ifdef AUTO_TRIG_EN
  localparam int TMO_W = $clog2(AUTO_TMO + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counts samples already seen in WAIT_TRIG; the AUTO_TMO-th one is forced
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (arm || state != WAIT_TRIG) begin
      tmo_cnt <= '0;
    end else if (sample_valid) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign fire = crossing || (tmo_cnt == TMO_W'(AUTO_TMO - 1));
`else
  assign fire = crossing;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ready       <= 1'b0;
      wr_ptr      <= '0;
      trig_ptr    <= '0;
      cnt         <= '0;
      prev_sample <= '0;
      prev_ok     <= 1'b0;
    end else if (arm) begin
      state   <= PRE;
      ready   <= 1'b0;
      cnt     <= '0;
      prev_ok <= 1'b0;
    end else begin
      if (sample_valid) begin
        prev_sample <= sample;
        prev_ok     <= 1'b1;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (sample_valid) begin
        case (state)
          PRE: begin
            if (cnt == PRE_LAST) begin
              state <= WAIT_TRIG;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_TRIG: begin
            if (fire) begin
              trig_ptr <= wr_ptr;
              // the trigger sample itself is the first of the post-trigger samples
              if (POST_LAST == '0) begin
                state <= DONE;
                ready <= 1'b1;
              end else begin
                state <= POST;
                cnt   <= CNT_W'(1);
              end
            end
          end
          POST: begin
            if (cnt == POST_LAST) begin
              state <= DONE;
              ready <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule
